clkdiv_ctrl: RTL and testbench
==============================

// Module: clkdiv_ctrl
// PURPOSE
//  Wishbone slave that programs and supervises the divide_by_N clock divider.
//  Owns the divider's n, enable and reset inputs and sequences every divisor change as disable, quiesce, reset, load, re-enable.
//  This keeps clk_out from producing a runt pulse during the change.
//  Also counts divided-clock rising edges for software rate checks.
// PARAMETERS
//  DEFAULT_N      8'd4  divisor loaded at reset
//  ENABLE_AT_RST  1'b0  CTRL.enable value after reset
//  QUIESCE_CYC    4     clk cycles with div_enable=0 before div_reset is pulsed (1..15)
//  RST_CYC        2     clk cycles div_reset is held high in a sequence (1..15)
// PORTS
//  clk          in   1   system clock; same clock that drives the divider
//  reset        in   1   asynchronous, active-high
//  wb_cyc_i     in   1   Wishbone cycle
//  wb_stb_i     in   1   Wishbone strobe
//  wb_we_i      in   1   write enable
//  wb_adr_i     in   4   byte address; bits [3:2] select the register
//  wb_sel_i     in   4   byte selects; only bit 0 is used
//  wb_dat_i     in   32  write data
//  wb_dat_o     out  32  read data
//  wb_ack_o     out  1   transfer acknowledge
//  div_n        out  8   divisor to divider
//  div_enable   out  1   divider enable
//  div_reset    out  1   divider reset, active-high
//  div_clk_in   in   1   divider clk_out, treated as asynchronous
// BEHAVIOUR
//  Register map:
//   0x0 CTRL   [0] enable (RW)
//   0x4 DIV    [7:0] n (RW); reads return the pending value if one exists, else div_n
//   0x8 STATUS [0] busy, [1] pending, [2] synced div_clk level (RO)
//   0xC EDGES  [15:0] rising-edge count (RO); any write clears it
//  Bus:
//   - ack is registered: high one cycle after cyc&stb, for exactly 1 cycle.
//   - No ack while ack is high, so back-to-back transfers take 2 cycles each.
//   - Write takes effect on the ack cycle.
//   - Writes with wb_sel_i[0]=0 are acked and ignored, except the EDGES clear.
//   - Unused read bits return 0.
//  Reset values:
//   - div_n=DEFAULT_N, div_enable=0, div_reset=1, wb_ack_o=0, wb_dat_o=0.
//   - EDGES=0, CTRL.enable=ENABLE_AT_RST, FSM state=S_RST.
//  FSM states: S_RST, S_RUN, S_DRAIN, S_DRST, S_LOAD.
//   - S_RST: div_reset=1 for RST_CYC cycles after reset release, then S_RUN.
//     On entry to S_RUN, div_enable=CTRL.enable.
//   - S_RUN:
//     - CTRL write: div_enable follows the new value 1 cycle after ack.
//     - DIV write: pending<=n, then S_DRAIN.
//   - S_DRAIN: div_enable=0 for QUIESCE_CYC cycles, then S_DRST.
//   - S_DRST: div_reset=1 for RST_CYC cycles, then S_LOAD.
//   - S_LOAD (1 cycle): div_n<=pending; div_reset=0; pending cleared; then S_RUN.
//     On entry to S_RUN, div_enable=CTRL.enable.
//   - busy=1 in every state except S_RUN.
//   - Sequence length from DIV ack to re-enable: QUIESCE_CYC+RST_CYC+2 cycles.
//  Boundary cases:
//   - Writing the same n as div_n still runs the full sequence (phase resync).
//   - DIV write while busy: the value overwrites pending, last write wins.
//     If it arrives before S_LOAD, the current sequence loads it; if it arrives in S_LOAD, a new sequence starts on S_RUN entry.
//   - CTRL write while busy: updates CTRL only; div_enable stays 0 until S_RUN.
//   - n=0 or n=1 is legal; the divider bypasses and passes clk through.
//   - reset mid-sequence: all state returns to reset values and pending is lost.
//  Edge counter:
//   - div_clk_in passes through a 2-FF synchronizer; rising edges are detected on the synced signal.
//   - 16-bit count that wraps at 0xFFFF->0.
//   - Edge and clear in the same cycle: clear wins, result 0.
//   - Counts only edges seen while div_enable=1.
// STRUCTURE
//  Shared package clkdiv_pkg: FSM state enum, register offsets, STATUS bit indices.
//  One sub-module, clkdiv_edge_cnt: synchronizer, edge detect and 16-bit counter.
//  FSM, register file and bus logic stay in the top level.
// TESTING
//  1. Reset release with defaults -> div_reset high 2 cycles, then div_n=4 and div_enable=0; reads return CTRL=0, DIV=4.
//  2. Write CTRL=1, then DIV=6 -> div_enable drops 1 cycle after the DIV ack.
//     Then div_reset high 2 cycles, div_n=6, and div_enable=1 exactly 8 cycles after the ack; STATUS.busy=1 throughout.
//  3. Write DIV=6 then DIV=10 while busy -> single sequence, final div_n=10, pending=0.
//  4. n=4, enabled, 1000 clk cycles -> EDGES reads 125 (+/-1); write EDGES -> reads 0.
//  5. Force the count to 0xFFFF -> next edge gives 0; edge coinciding with a clear gives 0.
//  6. Assert reset during S_DRST with pending=9 -> div_n=4, pending=0, FSM restarts in S_RST.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// Shared definitions for the clock-divider controller: FSM states, register
// offsets (word index from wb_adr_i[3:2]) and STATUS bit positions.
package clkdiv_pkg;

  typedef enum logic [2:0] {
    S_RST   = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_DRST  = 3'd3,
    S_LOAD  = 3'd4
  } state_t;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_DIV    = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_EDGES  = 2'd3;

  localparam int ST_BUSY  = 0;
  localparam int ST_PEND  = 1;
  localparam int ST_LEVEL = 2;

endpackage

// File: rtl/clkdiv_edge_cnt.sv
// Synchronizes the divided clock into clk, detects its rising edges and keeps
// a wrapping 16-bit count of those seen while the divider is enabled.
module clkdiv_edge_cnt (
  input  logic        clk,
  input  logic        reset,
  input  logic        div_clk,
  input  logic        count_en,
  input  logic        clear,
  output logic [15:0] count,
  output logic        level
);

  logic        sync1, sync2, sync_d;
  logic        rise;
  logic [15:0] count_nxt;

  assign level = sync2;
  assign rise  = sync2 & ~sync_d;

  // Clear has priority over a coincident edge.
  always_comb begin
    count_nxt = count;
    if (clear)
      count_nxt = '0;
    else if (rise && count_en)
      count_nxt = count + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sync_d <= 1'b0;
      count  <= '0;
    end else begin
      sync1  <= div_clk;
      sync2  <= sync1;
      sync_d <= sync2;
      count  <= count_nxt;
    end
  end

endmodule

// File: rtl/clkdiv_ctrl.sv
// Wishbone slave that owns the divider's n/enable/reset and sequences every
// divisor change as disable, quiesce, reset, load, re-enable.
module clkdiv_ctrl
  import clkdiv_pkg::*;
#(
  parameter logic [7:0]  DEFAULT_N     = 8'd4,
  parameter logic        ENABLE_AT_RST = 1'b0,
  parameter int unsigned QUIESCE_CYC   = 4,
  parameter int unsigned RST_CYC       = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic [7:0]  div_n,
  output logic        div_enable,
  output logic        div_reset,
  input  logic        div_clk_in
);

  localparam logic [3:0] Q_LAST = 4'(QUIESCE_CYC - 1);
  localparam logic [3:0] R_LAST = 4'(RST_CYC - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        ctrl_en, ctrl_en_nxt;
  logic [7:0]  pending, pending_nxt;
  logic        pend_valid, pend_valid_nxt;
  logic [7:0]  div_n_nxt;
  logic        div_enable_nxt, div_reset_nxt;
  logic        req, wr_ack, wr_byte, ctrl_wr, div_wr, edges_clr;
  logic [1:0]  reg_sel;
  logic [31:0] rd_data;
  logic [15:0] edge_count;
  logic        div_level;
  logic        unused_bits;

  // Handshake: the master raises cyc&stb and holds them (with we/adr/dat/sel)
  // until it has seen ack; ack is a registered one-cycle pulse, never issued
  // while ack is already high, and a write commits at the end of the ack cycle.
  assign reg_sel   = wb_adr_i[3:2];
  assign req       = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr_ack    = wb_ack_o & wb_cyc_i & wb_stb_i & wb_we_i;
  assign wr_byte   = wr_ack & wb_sel_i[0];
  assign ctrl_wr   = wr_byte && (reg_sel == REG_CTRL);
  assign div_wr    = wr_byte && (reg_sel == REG_DIV);
  assign edges_clr = wr_ack && (reg_sel == REG_EDGES);

  assign unused_bits = ^{wb_sel_i[3:1], wb_dat_i[31:8], wb_adr_i[1:0]};

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    ctrl_en_nxt    = ctrl_wr ? wb_dat_i[0] : ctrl_en;
    pending_nxt    = div_wr ? wb_dat_i[7:0] : pending;
    pend_valid_nxt = pend_valid;
    div_n_nxt      = div_n;
    case (state)
      S_RST: begin
        if (cnt == R_LAST) begin
          state_nxt = S_RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      // A write that landed during S_LOAD leaves pend_valid set, which
      // starts the next sequence straight away.
      S_RUN: begin
        if (div_wr || pend_valid)
          state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (cnt == Q_LAST) begin
          state_nxt = S_DRST;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      S_DRST: begin
        if (cnt == R_LAST) begin
          state_nxt = S_LOAD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      S_LOAD: begin
        state_nxt      = S_RUN;
        div_n_nxt      = pending;
        pend_valid_nxt = 1'b0;
      end
      default: begin
        state_nxt = S_RST;
        cnt_nxt   = '0;
      end
    endcase
    if (div_wr)
      pend_valid_nxt = 1'b1;
    div_enable_nxt = (state_nxt == S_RUN) & ctrl_en_nxt;
    div_reset_nxt  = (state_nxt == S_RST) || (state_nxt == S_DRST);
  end

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      REG_CTRL:   rd_data[0]   = ctrl_en;
      REG_DIV:    rd_data[7:0] = pend_valid ? pending : div_n;
      REG_STATUS: begin
        rd_data[ST_BUSY]  = (state != S_RUN);
        rd_data[ST_PEND]  = pend_valid;
        rd_data[ST_LEVEL] = div_level;
      end
      default:    rd_data[15:0] = edge_count;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_RST;
      cnt        <= '0;
      ctrl_en    <= ENABLE_AT_RST;
      pending    <= '0;
      pend_valid <= 1'b0;
      div_n      <= DEFAULT_N;
      div_enable <= 1'b0;
      div_reset  <= 1'b1;
      wb_ack_o   <= 1'b0;
      wb_dat_o   <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      ctrl_en    <= ctrl_en_nxt;
      pending    <= pending_nxt;
      pend_valid <= pend_valid_nxt;
      div_n      <= div_n_nxt;
      div_enable <= div_enable_nxt;
      div_reset  <= div_reset_nxt;
      wb_ack_o   <= req;
      wb_dat_o   <= (req && !wb_we_i) ? rd_data : '0;
    end
  end

  clkdiv_edge_cnt u_edge (
    .clk      (clk),
    .reset    (reset),
    .div_clk  (div_clk_in),
    .count_en (div_enable),
    .clear    (edges_clr),
    .count    (edge_count),
    .level    (div_level)
  );

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Bench for clkdiv_ctrl: directed bus transfers, hand-timed checks on the
// divider controls, and a read scoreboard drained by a monitor on each ack.
module tb_clkdiv_ctrl;

  localparam logic [3:0] A_CTRL   = 4'h0;
  localparam logic [3:0] A_DIV    = 4'h4;
  localparam logic [3:0] A_STATUS = 4'h8;
  localparam logic [3:0] A_EDGES  = 4'hC;

  logic        clk, reset;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [3:0]  wb_adr_i, wb_sel_i;
  logic [31:0] wb_dat_i, wb_dat_o;
  logic        wb_ack_o;
  logic [7:0]  div_n;
  logic        div_enable, div_reset, div_clk_in;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  int          tol_q[$];
  string       name_q[$];

  clkdiv_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .wb_cyc_i   (wb_cyc_i),
    .wb_stb_i   (wb_stb_i),
    .wb_we_i    (wb_we_i),
    .wb_adr_i   (wb_adr_i),
    .wb_sel_i   (wb_sel_i),
    .wb_dat_i   (wb_dat_i),
    .wb_dat_o   (wb_dat_o),
    .wb_ack_o   (wb_ack_o),
    .div_n      (div_n),
    .div_enable (div_enable),
    .div_reset  (div_reset),
    .div_clk_in (div_clk_in)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wb_xfer(input logic we, input logic [3:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel);
    int n;
    @(negedge clk);
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = we;
    wb_adr_i = adr;
    wb_dat_i = dat;
    wb_sel_i = sel;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!wb_ack_o && n < 16);
    if (!wb_ack_o) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: adr=%0h no ack after %0d cycles", adr, n);
    end else begin
      chk("ack_latency", n, 1);
      @(posedge clk);
      #1;
      chk("ack_single_cycle", {31'b0, wb_ack_o}, 0);
    end
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    wb_sel_i = 4'h0;
  endtask

  task automatic wb_write(input logic [3:0] adr, input logic [31:0] dat);
    wb_xfer(1'b1, adr, dat, 4'hF);
  endtask

  task automatic wb_read(input logic [3:0] adr, input logic [31:0] exp, input int tol,
                         input string name);
    exp_q.push_back(exp);
    tol_q.push_back(tol);
    name_q.push_back(name);
    wb_xfer(1'b0, adr, 32'h0, 4'hF);
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [31:0] mon_exp, mon_diff;
  int          mon_tol;
  string       mon_name;

  always @(negedge clk) begin
    if (wb_ack_o && !wb_we_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: got %0h expected no read", wb_dat_o);
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_tol  = tol_q.pop_front();
        mon_name = name_q.pop_front();
        mon_diff = (wb_dat_o > mon_exp) ? wb_dat_o - mon_exp : mon_exp - wb_dat_o;
        if ($isunknown(wb_dat_o) || mon_diff > 32'(mon_tol)) begin
          errors++;
          $display("FAIL %s: got %0h expected %0h (+/-%0d)", mon_name, wb_dat_o, mon_exp, mon_tol);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset      = 1'b1;
    wb_cyc_i   = 1'b0;
    wb_stb_i   = 1'b0;
    wb_we_i    = 1'b0;
    wb_adr_i   = 4'h0;
    wb_sel_i   = 4'h0;
    wb_dat_i   = 32'h0;
    div_clk_in = 1'b0;

    // 1. reset values and release sequence
    repeat (3) @(negedge clk);
    chk("rst_div_reset", {31'b0, div_reset}, 1);
    chk("rst_div_enable", {31'b0, div_enable}, 0);
    chk("rst_div_n", {24'b0, div_n}, 4);
    chk("rst_ack", {31'b0, wb_ack_o}, 0);
    chk("rst_dat", wb_dat_o, 0);
    reset = 1'b0;
    chk("rel_div_reset_c0", {31'b0, div_reset}, 1);
    cycles(1);
    chk("rel_div_reset_c1", {31'b0, div_reset}, 1);
    cycles(1);
    chk("rel_div_reset_c2", {31'b0, div_reset}, 0);
    chk("rel_div_n", {24'b0, div_n}, 4);
    chk("rel_div_enable", {31'b0, div_enable}, 0);
    wb_read(A_CTRL, 32'h0, 0, "rd_ctrl_rst");
    wb_read(A_DIV, 32'h4, 0, "rd_div_rst");
    wb_read(A_STATUS, 32'h0, 0, "rd_status_rst");
    wb_read(A_EDGES, 32'h0, 0, "rd_edges_rst");

    // 2. enable, then a divisor change: cycle c counts from the DIV ack cycle
    wb_write(A_CTRL, 32'h1);
    chk("ctrl_en_follow", {31'b0, div_enable}, 1);
    wb_write(A_DIV, 32'h6);
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) cycles(1);
      chk($sformatf("seq_en_c%0d", c), {31'b0, div_enable}, (c >= 8) ? 1 : 0);
      chk($sformatf("seq_rst_c%0d", c), {31'b0, div_reset}, (c == 5 || c == 6) ? 1 : 0);
      chk($sformatf("seq_n_c%0d", c), {24'b0, div_n}, (c >= 8) ? 6 : 4);
    end
    // same n again: full sequence, busy+pending visible until S_LOAD ends
    wb_write(A_DIV, 32'h6);
    wb_read(A_STATUS, 32'h3, 0, "busy_c1");
    wb_read(A_STATUS, 32'h3, 0, "busy_c3");
    wb_read(A_STATUS, 32'h3, 0, "busy_c5");
    wb_read(A_STATUS, 32'h3, 0, "busy_c7");
    wb_read(A_STATUS, 32'h0, 0, "idle_c9");
    chk("same_n_div_n", {24'b0, div_n}, 6);
    chk("same_n_enable", {31'b0, div_enable}, 1);

    // 3. two DIV writes inside one sequence: last write wins, one sequence only
    wb_write(A_DIV, 32'h6);
    wb_write(A_DIV, 32'hA);
    for (int c = 4; c <= 8; c++) begin
      cycles(1);
      chk($sformatf("lww_en_c%0d", c), {31'b0, div_enable}, (c == 8) ? 1 : 0);
      chk($sformatf("lww_n_c%0d", c), {24'b0, div_n}, (c == 8) ? 10 : 6);
    end
    cycles(4);
    chk("lww_single_seq", {31'b0, div_enable}, 1);
    wb_read(A_STATUS, 32'h0, 0, "lww_status");
    wb_read(A_DIV, 32'hA, 0, "lww_div");
    // sel[0]=0 writes are ignored
    wb_xfer(1'b1, A_DIV, 32'h3, 4'hE);
    wb_read(A_STATUS, 32'h0, 0, "sel0_no_seq");
    wb_read(A_DIV, 32'hA, 0, "sel0_div_kept");
    wb_xfer(1'b1, A_CTRL, 32'h0, 4'hE);
    chk("sel0_ctrl_kept", {31'b0, div_enable}, 1);

    // 4. n=4 for 1000 cycles: divided clock period 8 -> 125 rising edges
    wb_write(A_DIV, 32'h4);
    cycles(10);
    chk("rate_div_n", {24'b0, div_n}, 4);
    chk("rate_enable", {31'b0, div_enable}, 1);
    wb_xfer(1'b1, A_EDGES, 32'h0, 4'h0);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      div_clk_in = ((i / 4) % 2) != 0;
    end
    wb_read(A_EDGES, 32'd125, 1, "edges_rate");
    wb_xfer(1'b1, A_EDGES, 32'h0, 4'h0);
    wb_read(A_EDGES, 32'h0, 0, "edges_cleared");

    // 5. wrap and clear-vs-edge priority
    @(negedge clk);
    div_clk_in = 1'b0;
    cycles(4);
    @(negedge clk);
    force dut.u_edge.count = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.u_edge.count;
    wb_read(A_EDGES, 32'hFFFF, 0, "edges_forced");
    @(negedge clk);
    div_clk_in = 1'b1;
    cycles(4);
    wb_read(A_EDGES, 32'h0, 0, "edges_wrap");
    @(negedge clk);
    div_clk_in = 1'b0;
    cycles(3);
    @(negedge clk);
    div_clk_in = 1'b1;
    cycles(4);
    wb_read(A_EDGES, 32'h1, 0, "edges_one");
    @(negedge clk);
    div_clk_in = 1'b0;
    cycles(4);
    @(negedge clk);
    div_clk_in = 1'b1;
    wb_write(A_EDGES, 32'h0);
    cycles(4);
    wb_read(A_EDGES, 32'h0, 0, "edge_clear_same_cycle");
    wb_read(A_STATUS, 32'h4, 0, "status_level");
    // edges are not counted while the divider is disabled
    @(negedge clk);
    div_clk_in = 1'b0;
    wb_write(A_CTRL, 32'h0);
    chk("gate_enable_low", {31'b0, div_enable}, 0);
    repeat (3) begin
      @(negedge clk);
      div_clk_in = 1'b1;
      cycles(4);
      @(negedge clk);
      div_clk_in = 1'b0;
      cycles(4);
    end
    wb_read(A_EDGES, 32'h0, 0, "edges_gated");
    wb_write(A_CTRL, 32'h1);

    // 6. reset in S_DRST with pending=9
    wb_write(A_DIV, 32'h9);
    cycles(4);
    chk("drst_before_reset", {31'b0, div_reset}, 1);
    reset = 1'b1;
    #1;
    chk("midrst_div_n", {24'b0, div_n}, 4);
    chk("midrst_enable", {31'b0, div_enable}, 0);
    chk("midrst_div_reset", {31'b0, div_reset}, 1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rerel_rst_c0", {31'b0, div_reset}, 1);
    cycles(1);
    chk("rerel_rst_c1", {31'b0, div_reset}, 1);
    cycles(1);
    chk("rerel_rst_c2", {31'b0, div_reset}, 0);
    chk("rerel_enable", {31'b0, div_enable}, 0);
    wb_read(A_DIV, 32'h4, 0, "rerel_div");
    wb_read(A_STATUS, 32'h0, 0, "rerel_status");
    wb_read(A_CTRL, 32'h0, 0, "rerel_ctrl");
    wb_read(A_EDGES, 32'h0, 0, "rerel_edges");

    // ---------------- final report ----------------
    cycles(2);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d reads left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
